sr_tcam_ctrl: RTL and testbench

Controller for the SRAM-emulated TCAM: the 144-bit key is split into 72 two-bit chunks, each chunk indexes a 4-row × 256-bit SRAM slice, and the 72 row outputs are ANDed into a 256-bit match vector. This block shares the array between a search requester and a rule-update requester. It pipelines searches with priority-encoded results and expands ternary rule writes into the four per-row column writes the slices need. It sits between the lookup client/host config port and the TCAM array.

---
 rtl/sr_tcam_pkg.sv | 12 +
 rtl/sr_tcam_penc.sv | 22 ++
 rtl/sr_tcam_ctrl.sv | 152 +++++++++++++++
 tb/tb_sr_tcam_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_tcam_pkg.sv
// Shared constants and enums for the SRAM-emulated TCAM controller.
package sr_tcam_pkg;
   localparam int KEY_W   = 144;
   localparam int ENTRIES = 256;
   localparam int CHUNK_W = 2;
   localparam int CHUNKS  = KEY_W / CHUNK_W;
   localparam int ROWS    = 4;
   localparam int IDX_W   = 8;

   typedef enum logic {IDLE, WRITE} state_t;
   typedef enum logic {SRCH, UPD}   grant_t;
endpackage

// File: rtl/sr_tcam_penc.sv
// Lowest-index priority encoder over the array match vector.
module sr_tcam_penc
   import sr_tcam_pkg::*;
#(
   parameter int N  = ENTRIES,
   parameter int IW = IDX_W
) (
   input  logic [N-1:0]  match,
   output logic          hit,
   output logic [IW-1:0] index
);
   always_comb begin
      hit   = 1'b0;
      index = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (match[i] && !hit) begin
            hit   = 1'b1;
            index = IW'(i);
         end
      end
   end
endmodule

// File: rtl/sr_tcam_ctrl.sv
// Arbitrates searches and rule updates onto the shared TCAM array; pipelines
// searches and expands ternary rule writes into four per-row column writes.
module sr_tcam_ctrl #(
   parameter int KEY_W   = sr_tcam_pkg::KEY_W,
   parameter int ENTRIES = sr_tcam_pkg::ENTRIES,
   parameter int CHUNK_W = sr_tcam_pkg::CHUNK_W
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            srch_valid,
   output logic                            srch_ready,
   input  logic [KEY_W-1:0]                srch_key,
   output logic                            res_valid,
   output logic                            res_hit,
   output logic [sr_tcam_pkg::IDX_W-1:0]   res_index,
   input  logic                            upd_valid,
   output logic                            upd_ready,
   input  logic [sr_tcam_pkg::IDX_W-1:0]   upd_index,
   input  logic [KEY_W-1:0]                upd_value,
   input  logic [KEY_W-1:0]                upd_mask,
   input  logic                            upd_en,
   output logic                            arr_re,
   output logic [KEY_W-1:0]                arr_addr,
   input  logic [ENTRIES-1:0]              arr_match,
   output logic                            arr_we,
   output logic [1:0]                      arr_wrow,
   output logic [sr_tcam_pkg::IDX_W-1:0]   arr_wcol,
   output logic [KEY_W/CHUNK_W-1:0]        arr_wbits,
   output logic                            busy
);
   import sr_tcam_pkg::*;

   localparam int NCH = KEY_W / CHUNK_W;

   state_t             state_q, state_d;
   grant_t             last_q, last_d;
   logic [1:0]         row_q, row_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [KEY_W-1:0]   val_q, val_d, msk_q, msk_d, addr_q, addr_d;
   logic               en_q, en_d;
   logic               re_q, re_d, mv_q, mv_d, rv_q, rv_d, hit_q, hit_d;
   logic [IDX_W-1:0]   ridx_q, ridx_d;
   logic               srch_acc, upd_acc, enc_hit;
   logic [IDX_W-1:0]   enc_idx;

   sr_tcam_penc #(.N(ENTRIES), .IW(IDX_W)) u_penc (
      .match (arr_match),
      .hit   (enc_hit),
      .index (enc_idx)
   );

   always_comb begin
      // readies are gated by rst so every output reads 0 while reset is held
      srch_ready = !rst && (state_q == IDLE) && !(upd_valid && (last_q == SRCH));
      upd_ready  = !rst && (state_q == IDLE) && !(srch_valid && (last_q == UPD));
      srch_acc   = srch_valid && srch_ready;
      upd_acc    = upd_valid && upd_ready;

      state_d = state_q;
      last_d  = last_q;
      row_d   = row_q;
      idx_d   = idx_q;
      val_d   = val_q;
      msk_d   = msk_q;
      en_d    = en_q;
      addr_d  = addr_q;
      hit_d   = hit_q;
      ridx_d  = ridx_q;
      re_d    = srch_acc;
      mv_d    = re_q;
      rv_d    = mv_q;

      if (srch_acc) begin
         addr_d = srch_key;
         last_d = SRCH;
      end
      if (mv_q) begin
         hit_d  = enc_hit;
         ridx_d = enc_idx;
      end

      case (state_q)
         IDLE: begin
            if (upd_acc) begin
               state_d = WRITE;
               last_d  = UPD;
               row_d   = '0;
               idx_d   = upd_index;
               val_d   = upd_value;
               msk_d   = upd_mask;
               en_d    = upd_en;
            end
         end
         WRITE: begin
            if (row_q == 2'(ROWS - 1)) state_d = IDLE;
            else                       row_d   = row_q + 2'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // write bits follow the held rule registers, so they stay put between writes
   always_comb begin
      arr_wbits = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         arr_wbits[c] = en_q &&
            (((row_q ^ val_q[c*CHUNK_W +: CHUNK_W]) & ~msk_q[c*CHUNK_W +: CHUNK_W]) == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= SRCH;
         row_q   <= '0;
         idx_q   <= '0;
         val_q   <= '0;
         msk_q   <= '0;
         en_q    <= 1'b0;
         addr_q  <= '0;
         re_q    <= 1'b0;
         mv_q    <= 1'b0;
         rv_q    <= 1'b0;
         hit_q   <= 1'b0;
         ridx_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         row_q   <= row_d;
         idx_q   <= idx_d;
         val_q   <= val_d;
         msk_q   <= msk_d;
         en_q    <= en_d;
         addr_q  <= addr_d;
         re_q    <= re_d;
         mv_q    <= mv_d;
         rv_q    <= rv_d;
         hit_q   <= hit_d;
         ridx_q  <= ridx_d;
      end
   end

   assign arr_re    = re_q;
   assign arr_addr  = addr_q;
   assign arr_we    = (state_q == WRITE);
   assign busy      = (state_q == WRITE);
   assign arr_wrow  = row_q;
   assign arr_wcol  = idx_q;
   assign res_valid = rv_q;
   assign res_hit   = hit_q;
   assign res_index = ridx_q;
endmodule

// File: tb/tb_sr_tcam_ctrl.sv
// Randomised bench for sr_tcam_ctrl with an emulated SRAM array and a rule-table model.
module tb_sr_tcam_ctrl;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         srch_valid = 1'b0, srch_ready;
   logic [143:0] srch_key = '0;
   logic         res_valid, res_hit;
   logic [7:0]   res_index;
   logic         upd_valid = 1'b0, upd_ready;
   logic [7:0]   upd_index = '0;
   logic [143:0] upd_value = '0, upd_mask = '0;
   logic         upd_en = 1'b0;
   logic         arr_re, arr_we, busy;
   logic [143:0] arr_addr;
   logic [255:0] arr_match = '0;
   logic [1:0]   arr_wrow;
   logic [7:0]   arr_wcol;
   logic [71:0]  arr_wbits;

   always #5 clk = ~clk;

   sr_tcam_ctrl #(.KEY_W(144), .ENTRIES(256), .CHUNK_W(2)) dut (
      .clk(clk), .rst(rst),
      .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_key(srch_key),
      .res_valid(res_valid), .res_hit(res_hit), .res_index(res_index),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
      .upd_value(upd_value), .upd_mask(upd_mask), .upd_en(upd_en),
      .arr_re(arr_re), .arr_addr(arr_addr), .arr_match(arr_match),
      .arr_we(arr_we), .arr_wrow(arr_wrow), .arr_wcol(arr_wcol),
      .arr_wbits(arr_wbits), .busy(busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // rule table: what the array should hold, column by column
   logic         r_en [256];
   logic [143:0] r_val [256];
   logic [143:0] r_msk [256];

   function automatic logic [8:0] ref_search(input logic [143:0] key);
      for (int j = 0; j < 256; j++)
         if (r_en[j] && (((key ^ r_val[j]) & ~r_msk[j]) == '0)) return {1'b1, 8'(j)};
      return '0;
   endfunction

   function automatic logic [71:0] ref_wbits(input logic [1:0] row, input logic [143:0] val,
                                             input logic [143:0] msk, input logic en);
      logic [71:0] b;
      for (int c = 0; c < 72; c++)
         b[c] = en && ((val[2*c +: 2] & ~msk[2*c +: 2]) == (row & ~msk[2*c +: 2]));
      return b;
   endfunction

   function automatic logic [143:0] rnd144();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[143:0];
   endfunction

   // emulated SRAM slices: 72 slices x 4 rows x 256 columns
   logic [255:0] mem [72][4];
   always @(posedge clk) begin : array_model
      logic [255:0] m;
      if (arr_we)
         for (int c = 0; c < 72; c++) mem[c][arr_wrow][arr_wcol] <= arr_wbits[c];
      if (arr_re) begin
         m = '1;
         for (int c = 0; c < 72; c++) m &= mem[c][arr_addr[2*c +: 2]];
         arr_match <= m;
      end
   end

   typedef struct {int due; logic hit; logic [7:0] idx;} exp_t;
   exp_t         sbq[$];
   exp_t         e;
   int           cyc = 0, ua = -100;
   logic         sprev = 1'b0, last_srch = 1'b1, sacc, uacc;
   logic [143:0] skey_prev = '0, u_val = '0, u_msk = '0;
   logic [7:0]   u_idx = '0, lr_idx = '0;
   logic         u_en = 1'b0, lr_hit = 1'b0;
   logic [71:0]  last_wb [4];
   logic [8:0]   rr;

   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
         ua = -100; sprev = 1'b0; last_srch = 1'b1;
      end else begin
         cyc++;
         sacc = srch_valid && srch_ready;
         uacc = upd_valid && upd_ready;
         chk("we_window", arr_we, (cyc - ua >= 1) && (cyc - ua <= 4));
         chk("busy_window", busy, (cyc - ua >= 1) && (cyc - ua <= 4));
         if (arr_we) begin
            chk("wrow", arr_wrow, cyc - ua - 1);
            chk("wcol", arr_wcol, u_idx);
            chk("wbits", arr_wbits, ref_wbits(arr_wrow, u_val, u_msk, u_en));
            last_wb[arr_wrow] = arr_wbits;
         end
         chk("re_timing", arr_re, sprev);
         if (arr_re) chk("re_addr", arr_addr, skey_prev);
         if (arr_re || arr_we) chk("re_we_excl", arr_re && arr_we, 1'b0);
         if (busy) chk("ready_in_busy", {srch_ready, upd_ready}, 2'b00);
         if (srch_valid && upd_valid && !busy) begin
            chk("tie_one_accept", sacc ^ uacc, 1'b1);
            chk("tie_alternate", uacc, last_srch);
         end
         if (res_valid) begin
            lr_hit = res_hit; lr_idx = res_index;
            if (sbq.size() == 0) chk("res_unexpected", 1'b1, 1'b0);
            else begin
               e = sbq.pop_front();
               chk("res_latency", cyc, e.due);
               chk("res_hit", res_hit, e.hit);
               chk("res_index", res_index, e.idx);
            end
         end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            chk("res_missing", 1'b0, 1'b1);
            void'(sbq.pop_front());
         end
         if (sacc) begin
            rr = ref_search(srch_key);
            sbq.push_back('{cyc + 3, rr[8], rr[7:0]});
            last_srch = 1'b1;
         end
         if (uacc) begin
            r_en[upd_index] = upd_en; r_val[upd_index] = upd_value; r_msk[upd_index] = upd_mask;
            ua = cyc; u_idx = upd_index; u_val = upd_value; u_msk = upd_mask; u_en = upd_en;
            last_srch = 1'b0;
         end
         sprev = sacc;
         skey_prev = srch_key;
      end
   end

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic do_upd(input logic [7:0] idx, input logic [143:0] val,
                         input logic [143:0] msk, input logic en);
      logic acc = 1'b0;
      upd_index = idx; upd_value = val; upd_mask = msk; upd_en = en; upd_valid = 1'b1;
      for (int t = 0; t < 40 && !acc; t++) begin
         @(negedge clk);
         acc = upd_ready;
      end
      if (!acc) chk("upd_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      upd_valid = 1'b0;
   endtask

   task automatic do_srch(input logic [143:0] key, output int waited);
      logic acc = 1'b0;
      waited = 0;
      srch_key = key; srch_valid = 1'b1;
      for (int t = 0; t < 40 && !acc; t++) begin
         @(negedge clk);
         acc = srch_ready;
         if (!acc) waited++;
      end
      if (!acc) chk("srch_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      srch_valid = 1'b0;
   endtask

   logic [143:0] rk, rv, rm;
   int           w;

   initial begin
      for (int j = 0; j < 256; j++) begin r_en[j] = 1'b0; r_val[j] = '0; r_msk[j] = '0; end
      for (int c = 0; c < 72; c++) for (int r = 0; r < 4; r++) mem[c][r] = '0;
      #1;
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res", {res_hit, res_index}, 9'd0);
      chk("rst_arr", {arr_re, arr_we, busy, arr_wrow, arr_wcol}, 13'd0);
      chk("rst_addr", arr_addr, 144'd0);
      chk("rst_wbits", arr_wbits, 72'd0);
      chk("rst_ready", {srch_ready, upd_ready}, 2'b00);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // full wildcard at column 5 matches any key
      do_upd(8'd5, '0, '1, 1'b1);
      settle(5);
      for (int r = 0; r < 4; r++) chk("wild_rows", last_wb[r], {72{1'b1}});
      do_srch(144'h1234, w);
      settle(5);
      chk("tp_wild_hit", {lr_hit, lr_idx}, {1'b1, 8'd5});

      do_upd(8'd3, 144'hABCD, '0, 1'b1);
      do_upd(8'd9, '0, '1, 1'b1);
      do_upd(8'd5, '0, '0, 1'b0);
      settle(6);
      do_srch(144'hABCD, w);
      settle(5);
      chk("tp_exact", {lr_hit, lr_idx}, {1'b1, 8'd3});
      do_srch(144'hABCE, w);
      settle(5);
      chk("tp_fallback", {lr_hit, lr_idx}, {1'b1, 8'd9});

      do_upd(8'd3, 144'hABCD, '0, 1'b0);
      settle(5);
      for (int r = 0; r < 4; r++) chk("inval_rows", last_wb[r], 72'd0);
      do_srch(144'hABCD, w);
      settle(5);
      chk("tp_after_inval", {lr_hit, lr_idx}, {1'b1, 8'd9});
      do_upd(8'd9, '0, '0, 1'b0);
      settle(5);
      do_srch(rnd144(), w);
      settle(5);
      chk("tp_empty", {lr_hit, lr_idx}, 9'd0);

      // both requesters busy at once: grants must alternate
      fork
         begin
            int ws;
            for (int i = 0; i < 6; i++) begin
               rk = rnd144(); rk[15:0] = 16'($urandom_range(0, 15));
               do_srch(rk, ws);
            end
         end
         begin
            for (int i = 0; i < 6; i++)
               do_upd(8'($urandom_range(0, 15)), {128'd0, 16'($urandom_range(0, 15))},
                      {{128{1'b1}}, 16'h0000}, 1'b1);
         end
      join
      settle(8);

      // back-to-back searches with no competing updates
      for (int i = 0; i < 4; i++) begin
         rk = rnd144(); rk[15:0] = 16'(i * 3);
         do_srch(rk, w);
         chk("b2b_no_wait", w, 0);
      end
      settle(6);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            rv = {128'd0, 16'($urandom)};
            rm = {{128{1'b1}}, 16'($urandom) & 16'h0F0F};
            do_upd(8'($urandom_range(0, 20)), rv, rm, $urandom_range(0, 4) != 0);
         end else begin
            rk = rnd144();
            rk[15:0] = r_val[$urandom_range(0, 20)][15:0] ^ (($urandom_range(0, 3) == 0) ? 16'h0001 : 16'h0000);
            do_srch(rk, w);
         end
      end
      settle(8);

      // reset in the middle of a column write
      do_upd(8'd7, {128'd0, 16'h5A5A}, {{128{1'b1}}, 16'h0000}, 1'b1);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_we", {arr_we, busy, arr_re, res_valid}, 4'd0);
      chk("mid_rst_w", {arr_wrow, arr_wcol, arr_wbits}, 82'd0);
      chk("mid_rst_ready", {srch_ready, upd_ready}, 2'b00);
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 upd_valid = 1'b1;
      #1 chk("post_rst_upd_ready", upd_ready, 1'b1);
      upd_valid = 1'b0;
      srch_valid = 1'b1;
      #1 chk("post_rst_srch_ready", srch_ready, 1'b1);
      srch_valid = 1'b0;
      @(posedge clk); #1;
      do_upd(8'd7, {128'd0, 16'h5A5A}, {{128{1'b1}}, 16'h0000}, 1'b1);
      settle(5);
      rk = rnd144(); rk[15:0] = 16'h5A5A;
      do_srch(rk, w);
      do_srch(rnd144(), w);
      settle(10);
      chk("sb_drained", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
